// File: rtl/phase_pkg.sv
// rtl/phase_pkg.sv - shared state encoding and default phase table rule for phase_sequencer
package phase_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STEP     = 2'd2;
    localparam logic [1:0] ST_STOPPING = 2'd3;

    // Channel ch starts at phase ch, folded into the period.
    function automatic int default_phase(input int ch, input int period);
        return ch % period;
    endfunction

endpackage

// File: rtl/phase_chan.sv
// rtl/phase_chan.sv - per-channel phase compare with registered phase_en and phase_clk
module phase_chan #(
    parameter int PERIOD = 4,
    parameter int PH_W   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            active,
    input  logic [PH_W-1:0] ph,
    input  logic [PH_W-1:0] phase,
    output logic            phase_en,
    output logic            phase_clk
);

    localparam logic [PH_W:0] PERIOD_W = (PH_W+1)'(PERIOD);
    localparam logic [PH_W:0] HALF_W   = (PH_W+1)'(PERIOD / 2);

    logic [PH_W:0] diff;

    // Distance of ph past this channel's phase, modulo PERIOD (PERIOD need not be a power of two).
    always_comb begin
        if (ph >= phase) begin
            diff = {1'b0, ph} - {1'b0, phase};
        end else begin
            diff = {1'b0, ph} + PERIOD_W - {1'b0, phase};
        end
    end

    // Register the pulse and the first-half-of-period clock; both forced low when not active.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_en  <= 1'b0;
            phase_clk <= 1'b0;
        end else begin
            phase_en  <= active && (ph == phase);
            phase_clk <= active && (diff < HALF_W);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - multi-channel phase sequencer with run/step/stop FSM and double-buffered phase table
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PERIOD = 4,
    localparam int PH_W  = $clog2(PERIOD)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   step,
    input  logic                   cfg_valid,
    input  logic [NUM_CH*PH_W-1:0] cfg_phase,
    output logic                   cfg_ready,
    output logic                   cfg_err,
    output logic [NUM_CH-1:0]      phase_en,
    output logic [NUM_CH-1:0]      phase_clk,
    output logic                   busy,
    output logic [15:0]            period_cnt
);

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PERIOD - 1);
    localparam logic [PH_W:0]   PERIOD_W = (PH_W+1)'(PERIOD);

    function automatic logic [NUM_CH*PH_W-1:0] default_table();
        logic [NUM_CH*PH_W-1:0] t;
        t = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            t[i*PH_W +: PH_W] = PH_W'(default_phase(i, PERIOD));
        end
        return t;
    endfunction

    localparam logic [NUM_CH*PH_W-1:0] DEF_TBL = default_table();

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [PH_W-1:0]        ph;
    logic                   counting;
    logic                   wrap;
    logic                   chan_active;
    logic                   cfg_ok;
    logic                   pend_valid;
    logic [NUM_CH*PH_W-1:0] pend_tbl;
    logic [NUM_CH*PH_W-1:0] act_tbl;

    assign counting  = (state != ST_IDLE);
    assign wrap      = counting && (ph == PH_LAST);
    assign busy      = counting;
    assign cfg_ready = !pend_valid;
    // Channel outputs stop on the edge that returns to IDLE, so nothing leaks into the first idle cycle.
    assign chan_active = counting && (state_nxt != ST_IDLE);

    // Next-state logic; a RUN that loses enable on its last phase stops right away instead of running another period.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable)    state_nxt = ST_RUN;
                else if (step) state_nxt = ST_STEP;
            end
            ST_RUN: begin
                if (!enable) state_nxt = wrap ? ST_IDLE : ST_STOPPING;
            end
            ST_STEP, ST_STOPPING: begin
                if (wrap) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Offered table is accepted only if every field lies inside the period.
    always_comb begin
        cfg_ok = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if ({1'b0, cfg_phase[i*PH_W +: PH_W]} >= PERIOD_W) cfg_ok = 1'b0;
        end
    end

    // FSM state, phase counter and completed-period counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ph         <= '0;
            period_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (counting && !wrap) ph <= ph + PH_W'(1);
            else                   ph <= '0;
            if (wrap) period_cnt <= period_cnt + 16'd1;
        end
    end

    // Pending/active table pair: capture on handshake, promote in IDLE or on the wrap edge only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_tbl   <= '0;
            act_tbl    <= DEF_TBL;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_valid && cfg_ready && !cfg_ok;
            if (pend_valid && (state == ST_IDLE || wrap)) begin
                act_tbl    <= pend_tbl;
                pend_valid <= 1'b0;
            end else if (cfg_valid && cfg_ready && cfg_ok) begin
                pend_tbl   <= cfg_phase;
                pend_valid <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        phase_chan #(
            .PERIOD (PERIOD),
            .PH_W   (PH_W)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .active    (chan_active),
            .ph        (ph),
            .phase     (act_tbl[g*PH_W +: PH_W]),
            .phase_en  (phase_en[g]),
            .phase_clk (phase_clk[g])
        );
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - randomized self-checking bench for phase_sequencer against a behavioural model
module tb_phase_sequencer;

    localparam int NCH = 4;
    localparam int P   = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_STOP = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        step = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_phase = 8'h00;
    logic        cfg_ready, cfg_err, busy;
    logic [3:0]  phase_en, phase_clk;
    logic [15:0] period_cnt;

    logic        en2 = 1'b0;
    logic        step2 = 1'b0;
    logic        cv2 = 1'b0;
    logic [5:0]  cp2 = 6'd0;
    logic        cr2, ce2, busy2;
    logic [1:0]  pe2, pc2;
    logic [15:0] cnt2;

    phase_sequencer #(.NUM_CH(NCH), .PERIOD(P)) dut (
        .clock(clock), .reset(reset), .enable(enable), .step(step),
        .cfg_valid(cfg_valid), .cfg_phase(cfg_phase), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .phase_en(phase_en), .phase_clk(phase_clk), .busy(busy), .period_cnt(period_cnt)
    );

    phase_sequencer #(.NUM_CH(2), .PERIOD(6)) dut6 (
        .clock(clock), .reset(reset), .enable(en2), .step(step2),
        .cfg_valid(cv2), .cfg_phase(cp2), .cfg_ready(cr2), .cfg_err(ce2),
        .phase_en(pe2), .phase_clk(pc2), .busy(busy2), .period_cnt(cnt2)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode, position in period, tables, and the outputs visible in the current cycle.
    int       m_state, m_ph, m_cnt;
    int       m_act[NCH];
    int       m_pend[NCH];
    bit       m_pv, m_err;
    logic [3:0] m_en, m_clk;

    function automatic bit in_window(input int pos, input int start);
        for (int k = 0; k < P / 2; k++) if ((start + k) % P == pos) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_ph = 0; m_cnt = 0; m_pv = 0; m_err = 0;
        m_en = '0; m_clk = '0;
        for (int i = 0; i < NCH; i++) m_act[i] = i % P;
    endtask

    task automatic model_step();
        bit counting, last, stays, ok;
        int nxt;
        counting = (m_state != M_IDLE);
        last     = counting && (m_ph == P - 1);
        nxt      = m_state;
        if (m_state == M_IDLE)              nxt = enable ? M_RUN : (step ? M_STEP : M_IDLE);
        else if (m_state == M_RUN) begin
            if (!enable) nxt = last ? M_IDLE : M_STOP;
        end else if (last)                  nxt = M_IDLE;
        stays = counting && (nxt != M_IDLE);
        for (int i = 0; i < NCH; i++) begin
            m_en[i]  = stays && (m_ph == m_act[i]);
            m_clk[i] = stays && in_window(m_ph, m_act[i]);
        end
        ok = 1'b1;
        for (int i = 0; i < NCH; i++) if (int'(cfg_phase[i*2 +: 2]) >= P) ok = 1'b0;
        m_err = cfg_valid && !m_pv && !ok;
        if (m_pv && (m_state == M_IDLE || last)) begin
            m_act = m_pend;
            m_pv  = 1'b0;
        end else if (cfg_valid && !m_pv && ok) begin
            for (int i = 0; i < NCH; i++) m_pend[i] = int'(cfg_phase[i*2 +: 2]);
            m_pv = 1'b1;
        end
        m_ph = (counting && !last) ? m_ph + 1 : 0;
        if (last) m_cnt = (m_cnt + 1) % 65536;
        m_state = nxt;
    endtask

    task automatic compare_all();
        check("phase_en", phase_en, m_en);
        check("phase_clk", phase_clk, m_clk);
        check("busy", busy, m_state != M_IDLE);
        check("cfg_ready", cfg_ready, !m_pv);
        check("cfg_err", cfg_err, m_err);
        check("period_cnt", period_cnt, m_cnt);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic default_sequence(input string tag);
        logic [3:0] exp;
        enable = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp = (c >= 2) ? 4'(1 << (c - 2)) : 4'b0000;
            check({tag, "_en"}, phase_en, exp);
        end
        check({tag, "_cnt"}, period_cnt, 32'd1);
    endtask

    initial begin
        int fires[NCH];
        int cnt_before;
        bit bad;

        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        compare_all();
        check("rst_ready", cfg_ready, 32'd1);

        default_sequence("seq1");

        // Drop enable at ph=1: the period still finishes before IDLE.
        for (int k = 0; k < 10 && m_ph != 1; k++) tick();
        enable = 1'b0;
        repeat (4) tick();
        check("stop_busy", busy, 32'd0);
        check("stop_out", {phase_en, phase_clk}, 32'd0);

        // New table accepted at ph=2 only takes effect from the next ph=0.
        enable = 1'b1;
        for (int k = 0; k < 10 && !(m_state == M_RUN && m_ph == 2); k++) tick();
        cfg_valid = 1'b1;
        cfg_phase = 8'hF0;
        tick();
        cfg_valid = 1'b0;
        check("cfg_hold", cfg_ready, 32'd0);
        tick();
        check("cfg_rearm", cfg_ready, 32'd1);
        check("old_tbl_en", phase_en, 32'h8);
        tick();
        check("new_tbl_en", phase_en, 32'h3);

        // Single step with a table whose phases all fall before the last position.
        enable = 1'b0;
        for (int k = 0; k < 10 && m_state != M_IDLE; k++) tick();
        cfg_valid = 1'b1;
        cfg_phase = 8'hA4;
        tick();
        cfg_valid = 1'b0;
        tick();
        cnt_before = m_cnt;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < NCH; i++) fires[i] = 0;
        repeat (5) begin
            tick();
            for (int i = 0; i < NCH; i++) fires[i] += int'(phase_en[i]);
        end
        for (int i = 0; i < NCH; i++) check("step_fire", fires[i], 32'd1);
        check("step_cnt", period_cnt, 32'(16'(cnt_before + 1)));
        check("step_busy", busy, 32'd0);

        step = 1'b1;
        enable = 1'b1;
        tick();
        step = 1'b0;
        check("step_en_run", busy, 32'd1);

        // Asynchronous reset in mid-period with a table pending.
        for (int k = 0; k < 10 && m_ph != 1; k++) tick();
        cfg_valid = 1'b1;
        cfg_phase = 8'h1B;
        tick();
        cfg_valid = 1'b0;
        check("rst_pend", cfg_ready, 32'd0);
        #2 reset = 1'b0;
        #1;
        check("arst_out", {phase_en, phase_clk}, 32'd0);
        check("arst_busy", busy, 32'd0);
        check("arst_ready", cfg_ready, 32'd1);
        check("arst_cnt", period_cnt, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        compare_all();
        default_sequence("seq2");

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            step      = ($urandom_range(0, 9) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_phase = 8'($urandom);
            tick();
        end
        step = 1'b0;
        cfg_valid = 1'b0;
        enable = 1'b0;
        repeat (8) tick();

        // Out-of-range fields on a PERIOD=6 instance are rejected.
        for (int n = 0; n < 12; n++) begin
            cp2 = 6'($urandom);
            if (n % 2 == 1) cp2[2:0] = 3'($urandom_range(6, 7));
            bad = (cp2[2:0] >= 3'd6) || (cp2[5:3] >= 3'd6);
            cv2 = 1'b1;
            @(posedge clock);
            @(negedge clock);
            cv2 = 1'b0;
            check("p6_err", ce2, bad);
            check("p6_ready", cr2, bad);
            @(negedge clock);
            check("p6_err_pulse", ce2, 32'd0);
            check("p6_ready_back", cr2, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
